// File: rtl/sprite_pkg.sv
// Shared types, register offsets and colour helpers for the sprite compositor.
package sprite_pkg;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        en;
        logic        hflip;
    } sprite_regs_t;

    localparam int unsigned REG_X      = 0;
    localparam int unsigned REG_Y      = 1;
    localparam int unsigned REG_CTRL   = 2;
    localparam int unsigned REG_STRIDE = 4;

    // MSB replication keeps full-scale 565 values at full-scale 888.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
        return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
    endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-channel hit test and sprite ROM address generation (one pipeline stage).
module sprite_hit_unit
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = 32,
    parameter int unsigned SPRITE_H = 32,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  sprite_regs_t      regs_i,
    input  logic [9:0]        col_i,
    input  logic [9:0]        row_i,
    output logic              hit_o,
    output logic [ADDR_W-1:0] rom_addr_o
);

    localparam int unsigned XW = $clog2(SPRITE_W);
    localparam int unsigned YW = $clog2(SPRITE_H);

    logic [11:0]       col_ext, x_ext, x_end;
    logic [10:0]       row_ext, y_ext, y_end;
    logic              in_x, in_y;
    logic [XW-1:0]     dx, dx_eff;
    logic [YW-1:0]     dy;
    logic              hit_d, hit_q;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;

    // One extra bit on the bounds so sprites near the right/bottom edge clip instead of wrapping.
    always_comb begin
        col_ext = {2'b00, col_i};
        x_ext   = {1'b0, regs_i.x};
        x_end   = x_ext + 12'(SPRITE_W);
        row_ext = {1'b0, row_i};
        y_ext   = {1'b0, regs_i.y};
        y_end   = y_ext + 11'(SPRITE_H);
        in_x    = (col_ext >= x_ext) && (col_ext < x_end);
        in_y    = (row_ext >= y_ext) && (row_ext < y_end);
        dx      = XW'(col_ext - x_ext);
        dy      = YW'(row_ext - y_ext);
        // With a power-of-two width, SPRITE_W-1-dx is just the bitwise inverse.
        dx_eff  = regs_i.hflip ? ~dx : dx;
        hit_d   = regs_i.en && in_x && in_y;
        rom_addr_d = hit_d ? ADDR_W'({dy, dx_eff}) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q      <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            hit_q      <= hit_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign hit_o      = hit_q;
    assign rom_addr_o = rom_addr_q;

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: shadowed host registers, per-channel hit units,
// fixed-priority colour-keyed mux and a 3-cycle aligned pixel pipeline.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 8,
    parameter int unsigned SPRITE_W    = 32,
    parameter int unsigned SPRITE_H    = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter logic [15:0] TRANSP_KEY  = 16'hF81F,
    parameter logic [15:0] BG_RESET    = 16'hFFFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          chipselect,
    input  logic                          write,
    input  logic [8:0]                    address,
    input  logic [31:0]                   writedata,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    input  logic                          blank_n,
    input  logic                          frame_start,
    output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
    input  logic [NUM_SPRITES*16-1:0]     rom_data,
    output logic [7:0]                    pix_r,
    output logic [7:0]                    pix_g,
    output logic [7:0]                    pix_b,
    output logic                          pix_blank_n
);

    sprite_regs_t shadow_q [NUM_SPRITES];
    sprite_regs_t shadow_d [NUM_SPRITES];
    sprite_regs_t active_q [NUM_SPRITES];
    sprite_regs_t active_d [NUM_SPRITES];
    logic [15:0]  bg_shadow_q, bg_shadow_d;
    logic [15:0]  bg_active_q, bg_active_d;

    logic                   wr_en;
    logic [6:0]             wr_idx;
    logic [1:0]             wr_off;
    logic [9:0]             col;
    logic [NUM_SPRITES-1:0] hit_s0;
    logic [NUM_SPRITES-1:0] hit_s1_d, hit_s1_q;
    logic                   blank_s0_d, blank_s0_q;
    logic                   blank_s1_d, blank_s1_q;
    logic                   pix_blank_n_d, pix_blank_n_q;
    logic [15:0]            win_color;
    logic [23:0]            pix_d, pix_q;
    logic                   unused_bits;

    assign wr_en       = chipselect && write;
    assign wr_idx      = address[8:2];
    assign wr_off      = address[1:0];
    assign col         = hcount[10:1];
    assign unused_bits = ^{hcount[0], writedata[31:16]};

    // Host writes only touch the shadow set; frame_start copies the pre-write shadow to active.
    always_comb begin
        shadow_d    = shadow_q;
        bg_shadow_d = bg_shadow_q;
        if (wr_en) begin
            if (32'(address) == REG_STRIDE * NUM_SPRITES) begin
                bg_shadow_d = writedata[15:0];
            end else begin
                for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                    if (32'(wr_idx) == i) begin
                        case (32'(wr_off))
                            REG_X:    shadow_d[i].x = writedata[10:0];
                            REG_Y:    shadow_d[i].y = writedata[9:0];
                            REG_CTRL: begin
                                shadow_d[i].en    = writedata[0];
                                shadow_d[i].hflip = writedata[1];
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
        active_d    = frame_start ? shadow_q : active_q;
        bg_active_d = frame_start ? bg_shadow_q : bg_active_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            bg_shadow_q <= BG_RESET;
            bg_active_q <= BG_RESET;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            bg_shadow_q <= bg_shadow_d;
            bg_active_q <= bg_active_d;
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : gen_hit
        sprite_hit_unit #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H),
            .ADDR_W   (ADDR_W)
        ) u_hit (
            .clk        (clk),
            .reset      (reset),
            .regs_i     (active_q[g]),
            .col_i      (col),
            .row_i      (vcount),
            .hit_o      (hit_s0[g]),
            .rom_addr_o (rom_addr[g*ADDR_W +: ADDR_W])
        );
    end

    // Scan from the highest index down so the lowest-index opaque hit is written last and wins.
    always_comb begin
        hit_s1_d      = hit_s0;
        blank_s0_d    = blank_n;
        blank_s1_d    = blank_s0_q;
        pix_blank_n_d = blank_s1_q;
        win_color     = bg_active_q;
        for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
            if (hit_s1_q[i] && (rom_data[i*16 +: 16] != TRANSP_KEY)) begin
                win_color = rom_data[i*16 +: 16];
            end
        end
        pix_d = blank_s1_q ? rgb565_to_888(win_color) : 24'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_s1_q      <= '0;
            blank_s0_q    <= 1'b0;
            blank_s1_q    <= 1'b0;
            pix_blank_n_q <= 1'b0;
            pix_q         <= '0;
        end else begin
            hit_s1_q      <= hit_s1_d;
            blank_s0_q    <= blank_s0_d;
            blank_s1_q    <= blank_s1_d;
            pix_blank_n_q <= pix_blank_n_d;
            pix_q         <= pix_d;
        end
    end

    assign pix_r       = pix_q[23:16];
    assign pix_g       = pix_q[15:8];
    assign pix_b       = pix_q[7:0];
    assign pix_blank_n = pix_blank_n_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed plus randomized bench for sprite_compositor against a behavioural frame model.
module tb_sprite_compositor;

    localparam int NS = 8;
    localparam int W  = 32;
    localparam int H  = 32;
    localparam int AW = 10;
    localparam logic [15:0] KEY = 16'hF81F;

    logic             clk = 1'b0;
    logic             reset, chipselect, write, blank_n, frame_start;
    logic [8:0]       address;
    logic [31:0]      writedata;
    logic [10:0]      hcount;
    logic [9:0]       vcount;
    logic [NS*AW-1:0] rom_addr;
    logic [NS*16-1:0] rom_data = '0;
    logic [7:0]       pix_r, pix_g, pix_b;
    logic             pix_blank_n;

    sprite_compositor dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .address     (address),
        .writedata   (writedata),
        .hcount      (hcount),
        .vcount      (vcount),
        .blank_n     (blank_n),
        .frame_start (frame_start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .pix_blank_n (pix_blank_n)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents: either a flat colour or an address-derived pattern with keyed holes.
    logic [15:0] rom_const [NS];
    bit          rom_pat   [NS];

    function automatic logic [15:0] rom_val(input int ch, input int a);
        if (!rom_pat[ch]) return rom_const[ch];
        if (a % 8 == 3) return KEY;
        return 16'((a * 2654 + ch * 4951) ^ 32'h5A5A);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) rom_data[i*16 +: 16] <= rom_val(i, int'(rom_addr[i*AW +: AW]));
    end

    function automatic logic [23:0] expand(input logic [15:0] c);
        int r5, g6, b5;
        r5 = int'(c[15:11]);
        g6 = int'(c[10:5]);
        b5 = int'(c[4:0]);
        return {8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((b5 << 3) | (b5 >> 2))};
    endfunction

    // Reference model state
    int          sx [NS], sy [NS], ax [NS], ay [NS];
    bit          sen [NS], shf [NS], aen [NS], ahf [NS];
    logic [15:0] bg_s, bg_a, bg_last;
    logic [NS*AW-1:0] prev_addr;

    typedef struct packed {
        logic        bl;
        logic        fg;
        logic [15:0] c;
        logic        lv;
        logic [23:0] lit;
    } ent_t;
    ent_t exp_q [$];

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            sx[i] = 0; sy[i] = 0; sen[i] = 0; shf[i] = 0;
            ax[i] = 0; ay[i] = 0; aen[i] = 0; ahf[i] = 0;
        end
        bg_s = 16'hFFFF;
        bg_a = 16'hFFFF;
    endtask

    // One clock: drive inputs, predict, compare the output due now, then advance the model.
    task automatic cycle(input logic [10:0] hc, input logic [9:0] vc, input logic bl,
                         input logic fs, input logic wr, input logic [8:0] ad,
                         input logic [31:0] wd, input logic rs, input logic lv,
                         input logic [23:0] lit);
        ent_t e, f;
        int col, row, dx, a, idx, off;
        logic [NS*AW-1:0] addr_now;
        logic [23:0] exp_pix;
        hcount = hc; vcount = vc; blank_n = bl; frame_start = fs;
        chipselect = wr; write = wr; address = ad; writedata = wd; reset = rs;
        col = int'(hc) / 2;
        row = int'(vc);
        e = '0; e.bl = bl; e.lv = lv; e.lit = lit;
        addr_now = '0;
        for (int i = 0; i < NS; i++) begin
            if (aen[i] && col >= ax[i] && col < ax[i] + W && row >= ay[i] && row < ay[i] + H) begin
                dx = col - ax[i];
                if (ahf[i]) dx = W - 1 - dx;
                a = (row - ay[i]) * W + dx;
                addr_now[i*AW +: AW] = AW'(a);
                if (!e.fg && rom_val(i, a) != KEY) begin
                    e.fg = 1'b1;
                    e.c  = rom_val(i, a);
                end
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        f = exp_q.pop_front();
        exp_pix = f.bl ? expand(f.fg ? f.c : bg_last) : 24'h0;
        total++;
        assert ({pix_blank_n, pix_r, pix_g, pix_b} === {f.bl, exp_pix}) else begin
            bad++;
            $error("FAIL pix obs=%h exp=%h", {pix_blank_n, pix_r, pix_g, pix_b}, {f.bl, exp_pix});
        end
        if (f.lv) begin
            total++;
            assert ({pix_r, pix_g, pix_b} === f.lit) else begin
                bad++;
                $error("FAIL probe obs=%h exp=%h", {pix_r, pix_g, pix_b}, f.lit);
            end
        end
        total++;
        assert (rom_addr === prev_addr) else begin
            bad++;
            $error("FAIL rom_addr obs=%h exp=%h", rom_addr, prev_addr);
        end
        prev_addr = rs ? '0 : addr_now;
        if (rs) begin
            exp_q.delete();
            repeat (3) exp_q.push_back(ent_t'(0));
        end
        @(posedge clk);
        bg_last = bg_a;
        if (rs) begin
            model_reset();
        end else begin
            if (fs) begin
                for (int i = 0; i < NS; i++) begin
                    ax[i] = sx[i]; ay[i] = sy[i]; aen[i] = sen[i]; ahf[i] = shf[i];
                end
                bg_a = bg_s;
            end
            if (wr) begin
                idx = int'(ad) / 4;
                off = int'(ad) % 4;
                if (int'(ad) == 4 * NS) bg_s = wd[15:0];
                else if (idx < NS) begin
                    if (off == 0) sx[idx] = int'(wd & 32'h7FF);
                    if (off == 1) sy[idx] = int'(wd & 32'h3FF);
                    if (off == 2) begin sen[idx] = wd[0]; shf[idx] = wd[1]; end
                end
            end
        end
        #1;
    endtask

    task automatic px(input int col, input int row, input logic bl);
        cycle(11'(col * 2 + int'($urandom_range(0, 1))), 10'(row), bl, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic probe(input int col, input int row, input logic [23:0] lit);
        cycle(11'(col * 2), 10'(row), 1, 0, 0, 0, 0, 0, 1, lit);
    endtask

    task automatic wreg(input int ad, input int wd);
        cycle(0, 0, 0, 0, 1, 9'(ad), 32'(wd), 0, 0, 0);
    endtask

    task automatic fstart();
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic scan(input int row, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) px(c, row, c < 640);
    endtask

    initial begin
        int i, col, row, ad, wd, off;
        logic wr, fs, bl;
        for (int k = 0; k < NS; k++) begin rom_const[k] = 16'h0000; rom_pat[k] = 0; end
        reset = 1; chipselect = 0; write = 0; address = 0; writedata = 0;
        hcount = 0; vcount = 0; blank_n = 0; frame_start = 0;
        model_reset();
        bg_last = 16'hFFFF;
        prev_addr = '0;
        repeat (3) exp_q.push_back(ent_t'(0));
        @(posedge clk); #1;
        total++;
        assert ({pix_blank_n, pix_r, pix_g, pix_b, rom_addr} === '0) else begin
            bad++;
            $error("FAIL reset_state obs=%h", {pix_blank_n, pix_r, pix_g, pix_b, rom_addr});
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Disabled sprites: background only, blank alternating
        for (int c = 0; c < 40; c++) px(c, 10, c % 3 != 0);
        probe(5, 10, 24'hFFFFFF);

        // Single sprite edges
        wreg(0, 100); wreg(1, 50); wreg(2, 1);
        rom_const[0] = 16'hF800;
        fstart(); flush(2);
        scan(50, 95, 135);
        probe(100, 50, 24'hFF0000); probe(99, 50, 24'hFFFFFF);
        probe(132, 50, 24'hFFFFFF); probe(131, 50, 24'hFF0000);
        probe(100, 49, 24'hFFFFFF); probe(100, 81, 24'hFF0000); probe(100, 82, 24'hFFFFFF);

        // Overlap and transparency
        flush(4);
        wreg(0, 200); wreg(1, 100); wreg(4, 185); wreg(5, 95); wreg(6, 1);
        rom_const[0] = KEY; rom_const[1] = 16'h07E0;
        fstart(); flush(2);
        probe(200, 100, 24'h00FF00);
        scan(100, 180, 240);
        flush(4); rom_const[0] = 16'h001F; flush(4);
        probe(200, 100, 24'h0000FF); probe(186, 100, 24'h00FF00); probe(199, 100, 24'h00FF00);

        // Shadow commit timing
        wreg(8, 50); wreg(9, 150); wreg(10, 1);
        flush(4); rom_const[2] = 16'h0000; flush(2);
        fstart(); flush(2);
        for (int c = 295; c <= 310; c++) begin
            if (c == 302) cycle(11'(c * 2), 10'd150, 1, 0, 1, 9'd8, 32'd300, 0, 0, 0);
            else px(c, 150, 1);
        end
        probe(300, 150, 24'hFFFFFF); probe(50, 150, 24'h000000);
        cycle(0, 0, 0, 1, 1, 9'd8, 32'd400, 0, 0, 0);
        flush(2);
        probe(300, 150, 24'h000000); probe(400, 150, 24'hFFFFFF); probe(50, 150, 24'hFFFFFF);
        fstart(); flush(2);
        probe(400, 150, 24'h000000); probe(300, 150, 24'hFFFFFF);

        // Right-edge clip with hflip
        wreg(12, 630); wreg(13, 200); wreg(14, 3);
        flush(4); rom_pat[3] = 1; flush(2);
        fstart(); flush(2);
        scan(200, 625, 645);
        probe(0, 200, 24'hFFFFFF);
        scan(231, 625, 645);

        // Randomized traffic
        flush(4);
        for (int k = 0; k < NS; k++) begin
            rom_pat[k] = 1'($urandom_range(0, 1));
            rom_const[k] = ($urandom_range(0, 3) == 0) ? KEY : 16'($urandom);
        end
        flush(2);
        for (int n = 0; n < 4000; n++) begin
            i   = int'($urandom_range(0, NS - 1));
            col = (ax[i] + int'($urandom_range(0, 40)) - 4) & 1023;
            row = (ay[i] + int'($urandom_range(0, 40)) - 4) & 1023;
            wr  = ($urandom_range(0, 19) == 0);
            fs  = ($urandom_range(0, 49) == 0);
            bl  = ($urandom_range(0, 3) != 0);
            ad  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 511))
                                              : int'($urandom_range(0, 4 * NS));
            off = ad % 4;
            if (ad == 4 * NS)   wd = int'($urandom);
            else if (off == 0)  wd = int'($urandom_range(0, 700) | ($urandom & 32'hFFFF_F800));
            else if (off == 1)  wd = int'($urandom_range(0, 500));
            else                wd = int'($urandom_range(0, 3));
            cycle(11'(col * 2 + int'($urandom_range(0, 1))), 10'(row), bl, fs, wr,
                  9'(ad), 32'(wd), 0, 0, 0);
        end

        // Reset during active video
        flush(4);
        for (int k = 0; k < NS; k++) rom_pat[k] = 0;
        rom_const[0] = 16'hF800;
        wreg(0, 100); wreg(1, 50); wreg(2, 1);
        fstart(); flush(2);
        scan(50, 100, 106);
        cycle(11'(107 * 2), 10'd50, 1, 0, 0, 0, 0, 1, 0, 0);
        scan(50, 108, 115);
        fstart(); flush(2);
        probe(100, 50, 24'hFFFFFF); probe(200, 100, 24'hFFFFFF); probe(630, 200, 24'hFFFFFF);
        flush(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
